// File: rtl/v74x139_arb.sv
// rtl/v74x139_arb.sv - round-robin 4-way arbiter with 74x139-style decoded grant
// Registered IDLE/GRANT/RELEASE arbiter; a tenure ends on request drop, hold timeout or disable.
module v74x139_arb #(
  parameter int HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       G_IN_N,
  input  logic [3:0] REQ,
  output logic [3:0] Y_N,
  output logic       B,
  output logic       A,
  output logic       G_N,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic [1:0] win;
  logic       win_ok;
  logic       drop;

  // Scan from the farthest offset down so the offset nearest ptr wins.
  always_comb begin
    win    = 2'b00;
    win_ok = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (REQ[ptr + 2'(i)]) begin
        win    = ptr + 2'(i);
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    drop = 1'b0;
    if (!REQ[{B, A}] || (cnt == CNT_LAST) || G_IN_N) drop = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      ptr    <= 2'b00;
      cnt    <= 8'd0;
      {B, A} <= 2'b00;
      G_N    <= 1'b1;
      Y_N    <= 4'b1111;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (!G_IN_N && win_ok) begin
            state  <= GRANT;
            {B, A} <= win;
            G_N    <= 1'b0;
            Y_N    <= ~(4'b0001 << win);
            BUSY   <= 1'b1;
            cnt    <= 8'd0;
          end else begin
            state <= IDLE;
            G_N   <= 1'b1;
            Y_N   <= 4'b1111;
            BUSY  <= 1'b0;
          end
        end
        GRANT: begin
          if (drop) begin
            // Break before make: one dead cycle, pointer moves past the holder.
            state <= RELEASE;
            G_N   <= 1'b1;
            Y_N   <= 4'b1111;
            BUSY  <= 1'b0;
            ptr   <= {B, A} + 2'd1;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          G_N   <= 1'b1;
          Y_N   <= 4'b1111;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v74x139_arb.sv
// tb/tb_v74x139_arb.sv - directed scoreboard bench for v74x139_arb
module tb_v74x139_arb;

  logic       CLK;
  logic       RST_N;
  logic       G_IN_N;
  logic [3:0] REQ;
  logic [3:0] Y_N;
  logic       B;
  logic       A;
  logic       G_N;
  logic       BUSY;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [7:0] exp_q[$];

  v74x139_arb #(.HOLD_MAX(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .G_IN_N(G_IN_N), .REQ(REQ),
    .Y_N(Y_N), .B(B), .A(A), .G_N(G_N), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed observation: {Y_N, B, A, G_N, BUSY}
  function automatic logic [7:0] fg(input logic [1:0] i);
    logic [3:0] y;
    y = ~(4'b0001 << i);
    return {y, i, 1'b0, 1'b1};
  endfunction

  function automatic logic [7:0] fr(input logic [1:0] i);
    return {4'b1111, i, 1'b1, 1'b0};
  endfunction

  task automatic step(input logic rst, input logic g, input logic [3:0] r,
                      input logic [7:0] expv, input string tag);
    logic [7:0] obs;
    logic [7:0] e;
    @(negedge CLK);
    RST_N  = rst;
    G_IN_N = g;
    REQ    = r;
    exp_q.push_back(expv);
    @(posedge CLK);
    #1;
    obs = {Y_N, B, A, G_N, BUSY};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      total++;
      assert (($countones(~Y_N) <= 1) && (G_N === (Y_N == 4'b1111))) else begin
        bad++;
        $error("FAIL onehot_gvalid observed=Y_N:%b G_N:%b expected=onehot-or-none with G_N consistent",
               Y_N, G_N);
      end
    end
  end

  initial begin
    RST_N  = 1'b0;
    G_IN_N = 1'b1;
    REQ    = 4'b0000;

    step(0, 1, 4'b0000, fr(0), "reset_a");
    chk_en = 1'b1;
    step(0, 1, 4'b0000, fr(0), "reset_b");

    // First arbitration after reset starts at requester 0: 0110 -> 1
    step(1, 0, 4'b0110, fg(1), "first_grant");
    step(1, 0, 4'b0000, fr(1), "first_release");
    step(1, 0, 4'b0000, fr(1), "first_idle");

    // Round robin with all requesting, 8-cycle tenures
    step(0, 1, 4'b0000, fr(0), "rr_reset");
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) step(1, 0, 4'b1111, fg(2'(k % 4)), "rr_grant");
      step(1, 0, 4'b1111, fr(2'(k % 4)), "rr_release");
    end
    step(1, 0, 4'b0000, fr(0), "rr_idle");

    // Grant 2, other requests ignored, drop after 3 cycles, then grant 3
    step(1, 0, 4'b0100, fg(2), "drop_grant2");
    step(1, 0, 4'b0101, fg(2), "no_preempt_a");
    step(1, 0, 4'b1101, fg(2), "no_preempt_b");
    step(1, 0, 4'b1000, fr(2), "drop_release");
    step(1, 0, 4'b1000, fg(3), "drop_grant3");
    step(1, 0, 4'b0000, fr(3), "drop3_release");
    step(1, 0, 4'b0000, fr(3), "drop3_idle");

    // Disabled arbiter ignores requests; disabling mid-grant releases
    step(1, 1, 4'b0001, fr(3), "disabled_a");
    step(1, 1, 4'b0001, fr(3), "disabled_b");
    step(1, 0, 4'b0001, fg(0), "enable_grant0");
    step(1, 1, 4'b0001, fr(0), "disable_release");
    step(1, 1, 4'b0001, fr(0), "disable_idle");

    // Reset during grant of 3: no release cycle, then grant 3 again
    step(1, 0, 4'b1000, fg(3), "rst_grant3_a");
    step(1, 0, 4'b1000, fg(3), "rst_grant3_b");
    step(0, 0, 4'b1000, fr(0), "rst_mid_grant");
    step(1, 0, 4'b1000, fg(3), "post_rst_grant3");
    step(1, 0, 4'b0000, fr(3), "post_rst_release");
    step(1, 0, 4'b0000, fr(3), "post_rst_idle");

    // Simultaneous drop and timeout: single release, pointer advances once (to 2)
    for (int c = 0; c < 8; c++) step(1, 0, 4'b0010, fg(1), "sim_grant1");
    step(1, 0, 4'b0101, fr(1), "sim_release");
    step(1, 0, 4'b0101, fg(2), "sim_single_advance");
    step(1, 0, 4'b0000, fr(2), "sim_release2");
    step(1, 0, 4'b0000, fr(2), "final_idle");

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v74x139_arb.md
V74X139_ARB -- requirements
Module: v74x139_arb

Interface
REQ-001 Parameter HOLD_MAX, default 8, meaning maximum consecutive GRANT cycles per tenure (legal 2..255).
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-004 G_IN_N  input  1  active-low arbiter enable, 74x139 G-style polarity.
REQ-005 REQ  input  4  active-high request per requester; requester holds it high for the whole tenure.
REQ-006 Y_N  output  4  active-low one-hot grant, 74x139 Y-style encoding; 4'b1111 means no grant.
REQ-007 B  output  1  grant index MSB (decoder B select).
REQ-008 A  output  1  grant index LSB (decoder A select).
REQ-009 G_N  output  1  active-low grant-valid; 0 exactly when one Y_N bit is 0.
REQ-010 BUSY  output  1  high in GRANT state.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 Y_N SHALL equal the 74x139 decode of {B,A} when G_N=0, and 4'b1111 when G_N=1.
REQ-013 States SHALL be IDLE, GRANT and RELEASE, encoded in 2 bits; the fourth code SHALL go to IDLE.
REQ-014 Round-robin pointer PTR (2 bits) SHALL set search order PTR, PTR+1, PTR+2, PTR+3 (mod 4); the first REQ bit set in that order wins.
REQ-015 IDLE: if G_IN_N=0 and REQ!=0, next state SHALL be GRANT, {B,A}=winner, G_N=0, hold counter=0; otherwise stay IDLE with G_N=1.
REQ-016 Grant latency SHALL be one clock: a REQ sampled high at edge n gives G_N=0 after edge n.
REQ-017 GRANT: the hold counter SHALL increment by 1 each cycle and SHALL not wrap.
REQ-018 GRANT SHALL leave for RELEASE on the first edge where any of these holds: REQ[{B,A}]=0; counter=HOLD_MAX-1; G_IN_N=1.
REQ-019 On entry to RELEASE, G_N SHALL be 1, Y_N 4'b1111, and PTR SHALL be set to {B,A}+1 mod 4; {B,A} keep their last value.
REQ-020 RELEASE SHALL last exactly one cycle (break-before-make), then apply the IDLE arbitration rule with the updated PTR.
REQ-021 Requests from non-granted requesters during GRANT SHALL be ignored and never preempt the grant.
REQ-022 A request dropped in the same cycle it would win SHALL not be granted.
REQ-023 A tenure SHALL last at most HOLD_MAX cycles with G_N=0.
REQ-024 If G_IN_N stays 1, the block SHALL stay in or return to IDLE, and REQ SHALL be ignored.
REQ-025 Simultaneous REQ release and timeout SHALL give a single RELEASE cycle and a single PTR advance.

Reset
REQ-026 While RST_N=0 at a rising edge: state=IDLE, PTR=0, counter=0, {B,A}=2'b00, G_N=1, Y_N=4'b1111, BUSY=0.
REQ-027 Reset mid-GRANT SHALL drop the grant at that edge, with no RELEASE cycle.
REQ-028 The first arbitration after reset SHALL start from requester 0.

Verification
REQ-029 Reset, then REQ=4'b0110, G_IN_N=0 -> next cycle {B,A}=01, Y_N=4'b1101, G_N=0, BUSY=1.
REQ-030 REQ=4'b1111 held constantly, HOLD_MAX=8 -> grant order 0,1,2,3,0; each tenure 8 cycles, then 1 RELEASE cycle with Y_N=1111.
REQ-031 Grant to 2, then drop REQ[2] after 3 cycles, REQ[3]=1 -> RELEASE at next edge, then grant 3 (Y_N=4'b0111).
REQ-032 G_IN_N=1 with REQ=4'b0001 -> Y_N stays 1111; set G_IN_N=1 during GRANT -> RELEASE next edge.
REQ-033 Apply RST_N=0 during GRANT of requester 3 -> next edge Y_N=1111, {B,A}=00; after release, REQ=4'b1000 -> grant 3.
REQ-034 The bench SHALL check on every cycle that at most one Y_N bit is 0 and that G_N=0 iff Y_N!=4'b1111.
